// File: rtl/terrain_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : terrain_pkg
//  Description : Shared types and segment-boundary helpers for the terrain
//                probe scanner. This package holds:
//                  - the terrain class encoding;
//                  - the scan FSM state encoding;
//                  - helpers that derive where each terrain segment starts
//                    inside one terrain period.
//  Revision    : 1.0 - initial release
// ============================================================================
package terrain_pkg;

    // Per-tank terrain class as presented on terrain_class.
    typedef enum logic [1:0] {
        BOTTOM = 2'b00,
        DOWN   = 2'b01,
        UP     = 2'b10,
        TOP    = 2'b11
    } terrain_class_t;

    // Scan sequencer states.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        MOD      = 3'd2,
        CLASSIFY = 3'd3,
        STORE    = 3'd4,
        DONE     = 3'd5
    } scan_state_t;

    // Offset within a period where the plateau begins.
    function automatic int seg_top_lo(input int up_w);
        return up_w;
    endfunction

    // Offset within a period where the down ramp begins.
    function automatic int seg_down_lo(input int up_w, input int top_w);
        return up_w + top_w;
    endfunction

    // Offset within a period where the flat bottom begins.
    function automatic int seg_bottom_lo(input int up_w, input int top_w, input int down_w);
        return up_w + top_w + down_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/terrain_classify.sv
`default_nettype none
// ============================================================================
//  Module      : terrain_classify
//  Description : Combinational segment lookup. It maps an offset r within one
//                terrain period to a terrain class and a height above the
//                bottom. When i_left is set, the position lies before the
//                terrain origin and is reported as flat bottom.
//  Ports       : i_r     [XW:0]  offset within the period (< PERIOD)
//                i_left          position is left of the terrain origin
//                o_cls           terrain class
//                o_h     [XW-1:0] height above the bottom segment
//  Options     : TERRAIN_SLOPE_EN
//                  - defined:   ramps interpolate their height;
//                  - undefined: ramps report HEIGHT>>1.
//  Revision    : 1.0 - initial release
// ============================================================================
module terrain_classify
    import terrain_pkg::*;
#(
    parameter int XW     = 10,
    parameter int UP_W   = 24,
    parameter int TOP_W  = 64,
    parameter int DOWN_W = 24,
    parameter int HEIGHT = 24
) (
    input  logic [XW:0]    i_r,
    input  logic           i_left,
    output terrain_class_t o_cls,
    output logic [XW-1:0]  o_h
);

    localparam logic [XW:0]   c_top_lo    = (XW+1)'(seg_top_lo(UP_W));
    localparam logic [XW:0]   c_down_lo   = (XW+1)'(seg_down_lo(UP_W, TOP_W));
    localparam logic [XW:0]   c_bottom_lo = (XW+1)'(seg_bottom_lo(UP_W, TOP_W, DOWN_W));
    localparam logic [XW-1:0] c_height    = XW'(HEIGHT);

`ifdef TERRAIN_SLOPE_EN
    // Linear ramps only line up with the plateau when both ramps are
    // exactly as wide as the plateau is tall (45-degree slopes).
    if ((UP_W != DOWN_W) || (UP_W != HEIGHT)) begin : g_slope_geometry_check
        $error("terrain_classify: sloped ramps need UP_W == DOWN_W == HEIGHT");
    end

    logic [XW:0] w_down_off;
`else
    localparam logic [XW-1:0] c_ramp_half = XW'(HEIGHT >> 1);
`endif

    always_comb begin
        o_cls = BOTTOM;
        o_h   = '0;
`ifdef TERRAIN_SLOPE_EN
        w_down_off = i_r - c_down_lo;
`endif
        if (i_left) begin
            o_cls = BOTTOM;
            o_h   = '0;
        end else if (i_r < c_top_lo) begin
            o_cls = UP;
`ifdef TERRAIN_SLOPE_EN
            o_h   = i_r[XW-1:0];
`else
            o_h   = c_ramp_half;
`endif
        end else if (i_r < c_down_lo) begin
            o_cls = TOP;
            o_h   = c_height;
        end else if (i_r < c_bottom_lo) begin
            o_cls = DOWN;
`ifdef TERRAIN_SLOPE_EN
            o_h   = c_height - w_down_off[XW-1:0];
`else
            o_h   = c_ramp_half;
`endif
        end
    end

endmodule
`default_nettype wire

// File: rtl/terrain_probe_scan.sv
`default_nettype none
// ============================================================================
//  Module      : terrain_probe_scan
//  Description : Time-multiplexed terrain classifier for N tanks.
//                On start, it snapshots every tank's X and size. It then walks
//                the channels through one shared LOAD/MOD/CLASSIFY/STORE
//                datapath. At the end of the scan it publishes each tank's
//                terrain class and floor Y.
//  Ports       : frame_clk                clock
//                Reset                    asynchronous active-low reset
//                start                    scan request (honoured in IDLE only)
//                x_flat   [N*XW-1:0]      tank X, channel i at [i*XW +: XW]
//                s_flat   [N*XW-1:0]      tank size, same packing
//                busy                     scan in progress
//                done                     one-cycle pulse, outputs just updated
//                terrain_class [2*N-1:0]  per-channel class (2 bits each)
//                floor_y  [N*XW-1:0]      per-channel floor Y
//  Options     : TERRAIN_SLOPE_EN (interpolated ramp heights, see
//                terrain_classify)
//  Revision    : 1.0 - initial release
// ============================================================================
module terrain_probe_scan
    import terrain_pkg::*;
#(
    parameter int N      = 2,
    parameter int XW     = 10,
    parameter int ORIGIN = 30,
    parameter int PERIOD = 160,
    parameter int UP_W   = 24,
    parameter int TOP_W  = 64,
    parameter int DOWN_W = 24,
    parameter int HEIGHT = 24,
    parameter int BASE_Y = 440
) (
    input  logic              frame_clk,
    input  logic              Reset,
    input  logic              start,
    input  logic [N*XW-1:0]   x_flat,
    input  logic [N*XW-1:0]   s_flat,
    output logic              busy,
    output logic              done,
    output logic [2*N-1:0]    terrain_class,
    output logic [N*XW-1:0]   floor_y
);

    localparam int              c_cw     = (N > 1) ? $clog2(N) : 1;
    localparam logic [c_cw-1:0] c_last   = c_cw'(N - 1);
    localparam logic [XW:0]     c_origin = (XW+1)'(ORIGIN);
    localparam logic [XW:0]     c_period = (XW+1)'(PERIOD);
    localparam logic [XW-1:0]   c_base_y = XW'(BASE_Y);

    scan_state_t     r_state;
    scan_state_t     w_state_nxt;
    logic [N*XW-1:0] r_x;
    logic [N*XW-1:0] r_s;
    logic [c_cw-1:0] r_ch;
    logic [XW:0]     r_r;
    logic            r_left;
    terrain_class_t  r_cls;
    logic [XW-1:0]   r_h;
    logic [2*N-1:0]  r_sh_class;
    logic [N*XW-1:0] r_sh_y;

    logic [XW-1:0]   w_x;
    logic [XW-1:0]   w_s;
    logic [XW:0]     w_xc;
    logic [XW-1:0]   w_y;
    terrain_class_t  w_cls;
    logic [XW-1:0]   w_h;

    assign w_x  = r_x[r_ch*XW +: XW];
    assign w_s  = r_s[r_ch*XW +: XW];
    // Tank centre; one extra bit so x + s/2 cannot wrap.
    assign w_xc = {1'b0, w_x} + {1'b0, (w_s >> 1)};
    assign w_y  = c_base_y - r_h;

    terrain_classify #(
        .XW     (XW),
        .UP_W   (UP_W),
        .TOP_W  (TOP_W),
        .DOWN_W (DOWN_W),
        .HEIGHT (HEIGHT)
    ) u_classify (
        .i_r    (r_r),
        .i_left (r_left),
        .o_cls  (w_cls),
        .o_h    (w_h)
    );

    always_comb begin
        w_state_nxt = r_state;
        busy        = (r_state != IDLE);
        done        = (r_state == DONE);
        case (r_state)
            IDLE:     if (start) w_state_nxt = LOAD;
            LOAD:     w_state_nxt = (w_xc < c_origin) ? CLASSIFY : MOD;
            MOD:      if (r_r < c_period) w_state_nxt = CLASSIFY;
            CLASSIFY: w_state_nxt = STORE;
            STORE:    w_state_nxt = (r_ch == c_last) ? DONE : LOAD;
            DONE:     w_state_nxt = IDLE;
            default:  w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge frame_clk or negedge Reset) begin
        if (!Reset) begin
            r_state       <= IDLE;
            r_x           <= '0;
            r_s           <= '0;
            r_ch          <= '0;
            r_r           <= '0;
            r_left        <= 1'b0;
            r_cls         <= BOTTOM;
            r_h           <= '0;
            r_sh_class    <= '0;
            r_sh_y        <= {N{c_base_y}};
            terrain_class <= '0;
            floor_y       <= {N{c_base_y}};
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_x  <= x_flat;
                        r_s  <= s_flat;
                        r_ch <= '0;
                    end
                end
                LOAD: begin
                    // The difference is meaningless when left; classify ignores it.
                    r_left <= (w_xc < c_origin);
                    r_r    <= w_xc - c_origin;
                end
                MOD: begin
                    if (r_r >= c_period) r_r <= r_r - c_period;
                end
                CLASSIFY: begin
                    r_cls <= w_cls;
                    r_h   <= w_h;
                end
                STORE: begin
                    r_sh_class[r_ch*2 +: 2] <= r_cls;
                    r_sh_y[r_ch*XW +: XW]   <= w_y;
                    if (r_ch == c_last) begin
                        // Publish on entry to DONE so the outputs are already
                        // valid in the cycle where done is high. The last
                        // channel bypasses its shadow slot, which is only
                        // being written on this same edge.
                        for (int j = 0; j < N; j++) begin
                            if (j == N - 1) begin
                                terrain_class[j*2 +: 2] <= r_cls;
                                floor_y[j*XW +: XW]     <= w_y;
                            end else begin
                                terrain_class[j*2 +: 2] <= r_sh_class[j*2 +: 2];
                                floor_y[j*XW +: XW]     <= r_sh_y[j*XW +: XW];
                            end
                        end
                    end else begin
                        r_ch <= r_ch + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_terrain_probe_scan.sv
`default_nettype none
// ============================================================================
//  Module      : tb_terrain_probe_scan
//  Description : Self-checking bench for terrain_probe_scan.
//                A behavioural reference computes class, floor Y and scan
//                latency directly from the terrain geometry. A per-cycle
//                compare checks busy, done and the outputs against that
//                reference. Directed cases also carry hand-computed literal
//                expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_terrain_probe_scan;

    localparam int N  = 2;
    localparam int XW = 10;

    logic            frame_clk = 1'b0;
    logic            Reset     = 1'b0;
    logic            start     = 1'b0;
    logic [N*XW-1:0] x_flat    = '0;
    logic [N*XW-1:0] s_flat    = '0;
    logic            busy;
    logic            done;
    logic [2*N-1:0]  terrain_class;
    logic [N*XW-1:0] floor_y;

    int n_checks = 0;
    int n_fail   = 0;

    terrain_probe_scan #(.N(N), .XW(XW)) dut (
        .frame_clk     (frame_clk),
        .Reset         (Reset),
        .start         (start),
        .x_flat        (x_flat),
        .s_flat        (s_flat),
        .busy          (busy),
        .done          (done),
        .terrain_class (terrain_class),
        .floor_y       (floor_y)
    );

    always #5 frame_clk = ~frame_clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Geometry: origin 30, period 160.
    // Segments: up [0,24), plateau [24,88), down [88,112), bottom beyond.
    function automatic void ref_channel(input int x, input int s,
                                        output int cls, output int y, output int cost);
        int xc;
        int r;
        int h;
        xc = x + s / 2;
        if (xc < 30) begin
            cls = 0; y = 440; cost = 3;
            return;
        end
        r    = (xc - 30) % 160;
        cost = (xc - 30) / 160 + 4;
        if (r < 24) begin
            cls = 2;
`ifdef TERRAIN_SLOPE_EN
            h = r;
`else
            h = 12;
`endif
        end else if (r < 88) begin
            cls = 3; h = 24;
        end else if (r < 112) begin
            cls = 1;
`ifdef TERRAIN_SLOPE_EN
            h = 24 - (r - 88);
`else
            h = 12;
`endif
        end else begin
            cls = 0; h = 0;
        end
        y = 440 - h;
    endfunction

    int m_rem;          // cycles left in the current scan, 0 when idle
    int m_cls [N];
    int m_y   [N];
    int m_pcls[N];
    int m_py  [N];
    int m_cost;
    int m_tot;

    initial begin
        m_rem = 0;
        for (int i = 0; i < N; i++) begin m_cls[i] = 0; m_y[i] = 440; end
        forever begin
            @(posedge frame_clk or negedge Reset);
            if (!Reset) begin
                m_rem = 0;
                for (int i = 0; i < N; i++) begin m_cls[i] = 0; m_y[i] = 440; end
            end else if (frame_clk) begin
                if (m_rem == 0) begin
                    if (start) begin
                        m_tot = 1;
                        for (int i = 0; i < N; i++) begin
                            ref_channel(int'(x_flat[i*XW +: XW]), int'(s_flat[i*XW +: XW]),
                                        m_pcls[i], m_py[i], m_cost);
                            m_tot += m_cost;
                        end
                        m_rem = m_tot;
                    end
                end else begin
                    m_rem--;
                    if (m_rem == 1)
                        for (int i = 0; i < N; i++) begin m_cls[i] = m_pcls[i]; m_y[i] = m_py[i]; end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge frame_clk) begin
        if (Reset) begin
            check("busy", int'(busy), int'(m_rem > 0));
            check("done", int'(done), int'(m_rem == 1));
            for (int i = 0; i < N; i++) begin
                check("class", int'(terrain_class[i*2 +: 2]), m_cls[i]);
                check("floor_y", int'(floor_y[i*XW +: XW]), m_y[i]);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic run_scan(input string tag, input int x0, input int s0, input int x1, input int s1,
                            input int lat, input int c0, input int y0, input int c1, input int y1);
        int n;
        @(negedge frame_clk);
        x_flat = {XW'(x1), XW'(x0)};
        s_flat = {XW'(s1), XW'(s0)};
        start  = 1'b1;
        @(negedge frame_clk);
        start = 1'b0;
        n = 1;
        while (!done && n < 200) begin
            @(negedge frame_clk);
            n++;
        end
        check({tag, "_latency"}, n, lat);
        check({tag, "_cls0"}, int'(terrain_class[1:0]), c0);
        check({tag, "_y0"}, int'(floor_y[XW-1:0]), y0);
        check({tag, "_cls1"}, int'(terrain_class[3:2]), c1);
        check({tag, "_y1"}, int'(floor_y[2*XW-1:XW]), y1);
    endtask

    int n_done;
    int first_done;
    int last_done;

    initial begin
        repeat (3) @(negedge frame_clk);
        // Reset values hold while reset is still asserted.
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_class", int'(terrain_class), 0);
        check("rst_floor", int'(floor_y), (440 << 10) | 440);
        Reset = 1'b1;

        run_scan("plateau_down", 60, 20, 130, 0, 9, 3, 416, 1, 428);
`ifdef TERRAIN_SLOPE_EN
        run_scan("up_wrap", 200, 0, 30, 0, 10, 2, 430, 2, 440);
`else
        run_scan("up_wrap", 200, 0, 30, 0, 10, 2, 428, 2, 428);
`endif
        run_scan("left_bottom", 10, 0, 170, 0, 8, 0, 440, 0, 440);
        run_scan("plateau_down2", 60, 20, 130, 0, 9, 3, 416, 1, 428);

        // Reset while channel 0 is still reducing modulo the period.
        @(negedge frame_clk);
        x_flat = {XW'(0), XW'(200)};
        s_flat = '0;
        start  = 1'b1;
        @(negedge frame_clk);
        start = 1'b0;
        @(negedge frame_clk);
        Reset = 1'b0;
        @(negedge frame_clk);
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_class", int'(terrain_class), 0);
        check("midrst_floor", int'(floor_y), (440 << 10) | 440);
        Reset = 1'b1;
        run_scan("after_rst", 10, 0, 170, 0, 8, 0, 440, 0, 440);

        // start pulses while busy and during DONE must not add a scan.
        @(negedge frame_clk);
        x_flat = {XW'(30), XW'(200)};
        s_flat = '0;
        start  = 1'b1;
        n_done = 0;
        for (int n = 1; n <= 30; n++) begin
            @(negedge frame_clk);
            if (done) n_done++;
            start = (n == 3) || (n == 10);
        end
        start = 1'b0;
        check("ignored_start_dones", n_done, 1);

        // start held high gives back-to-back scans with one idle cycle between.
        @(negedge frame_clk);
        x_flat = {XW'(130), XW'(60)};
        s_flat = {XW'(0), XW'(20)};
        start  = 1'b1;
        n_done = 0; first_done = 0; last_done = 0;
        for (int n = 1; n <= 45; n++) begin
            @(negedge frame_clk);
            if (done) begin
                n_done++;
                if (first_done == 0) first_done = n;
                last_done = n;
            end
            if (n == 35) start = 1'b0;
        end
        check("held_dones", n_done, 4);
        check("held_first", first_done, 9);
        check("held_span", last_done - first_done, 30);

        repeat (2) @(negedge frame_clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
